// File: rtl/decay_scheduler.sv
// decay_scheduler
//   Holds N_NEURONS IEEE-754 membrane potentials and their 4-bit decay-rate
//   codes. Each timestep pulse starts a sweep that hands every potential, one
//   at a time, to a shared decay unit and writes the returned value back.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   timestep                      one-cycle pulse that starts a sweep
//   cfg_we/cfg_addr/cfg_rate      rate-code write (illegal codes pulse cfg_err)
//   wr_en/wr_addr/wr_data         potential update, accepted when wr_ready=1
//   wr_ready                      high only while idle
//   rd_addr/rd_data               combinational potential read
//   dec_req/dec_potential/dec_rate  request to the decay unit
//   dec_done/dec_result           decay unit completion and result
//   busy, sweep_done, overrun, cfg_err, dec_err  status
//
// Build option
//   DECAY_TIMEOUT_EN  enables a WAIT watchdog of TIMEOUT cycles; on expiry the
//                     neuron keeps its old potential, dec_err is set and the
//                     sweep moves on. Without it WAIT never times out and
//                     dec_err is tied low.
//
// state | meaning
// IDLE  | no sweep; potential writes accepted
// ISSUE | dec_req high for the current neuron
// WAIT  | request held stable until dec_done
// WRITE | captured result written back, advance or finish
// DONE  | sweep_done pulse

module decay_scheduler #(
  parameter int          N_NEURONS      = 4,
  parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852,
  parameter int          TIMEOUT        = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        timestep,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [3:0]  cfg_rate,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        dec_req,
  output logic [31:0] dec_potential,
  output logic [3:0]  dec_rate,
  input  logic        dec_done,
  input  logic [31:0] dec_result,
  output logic        busy,
  output logic        sweep_done,
  output logic        overrun,
  output logic        cfg_err,
  output logic        dec_err
);

  if (N_NEURONS < 1 || N_NEURONS > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("decay_scheduler: N_NEURONS must be 1..4 and TIMEOUT >= 1");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state;
  logic [1:0]  index;
  logic [31:0] pot  [N_NEURONS];
  logic [3:0]  rate [N_NEURONS];
  logic [31:0] result_q;
  logic        wb_valid;

  logic        cfg_legal;
  logic        wr_accept;
  logic        is_last;
  logic [1:0]  next_idx;
  logic [31:0] issue_pot;
  logic [3:0]  issue_rate;

  assign wr_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign dec_req    = (state == S_ISSUE);
  assign sweep_done = (state == S_DONE);
  assign wr_accept  = wr_en && wr_ready;
  assign is_last    = (index == 2'(N_NEURONS - 1));
  assign next_idx   = (state == S_IDLE) ? 2'd0 : index + 2'd1;

  always_comb begin
    unique case (cfg_rate)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011: cfg_legal = 1'b1;
      default:                                     cfg_legal = 1'b0;
    endcase
  end

  // The request registers are loaded on the edge that enters ISSUE, so a
  // potential write or rate write landing on that same edge is forwarded.
  always_comb begin
    rd_data    = '0;
    issue_pot  = '0;
    issue_rate = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (rd_addr == 2'(i)) rd_data = pot[i];
      if (next_idx == 2'(i)) begin
        issue_pot  = pot[i];
        issue_rate = rate[i];
      end
    end
    if (wr_accept && wr_addr == next_idx) issue_pot = wr_data;
    if (cfg_we && cfg_legal && cfg_addr == next_idx) issue_rate = cfg_rate;
  end

`ifdef DECAY_TIMEOUT_EN
  logic [15:0] wd_cnt;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      index         <= '0;
      dec_potential <= '0;
      dec_rate      <= '0;
      overrun       <= 1'b0;
      cfg_err       <= 1'b0;
      result_q      <= '0;
      wb_valid      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot[i]  <= INIT_POTENTIAL;
        rate[i] <= 4'b0001;
      end
`ifdef DECAY_TIMEOUT_EN
      wd_cnt  <= '0;
      dec_err <= 1'b0;
`endif
    end else begin
      cfg_err <= cfg_we && !cfg_legal;
      if (timestep && state != S_IDLE) overrun <= 1'b1;

      for (int i = 0; i < N_NEURONS; i++) begin
        if (cfg_we && cfg_legal && cfg_addr == 2'(i)) rate[i] <= cfg_rate;
        if (wr_accept && wr_addr == 2'(i)) pot[i] <= wr_data;
      end

      case (state)
        S_IDLE: begin
          if (timestep) begin
            index         <= '0;
            dec_potential <= issue_pot;
            dec_rate      <= issue_rate;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef DECAY_TIMEOUT_EN
          wd_cnt <= 16'(TIMEOUT - 1);
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (dec_done) begin
            result_q <= dec_result;
            wb_valid <= 1'b1;
            state    <= S_WRITE;
          end
`ifdef DECAY_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            // Give up on this neuron: keep its potential and move on.
            dec_err  <= 1'b1;
            wb_valid <= 1'b0;
            state    <= S_WRITE;
          end else begin
            wd_cnt <= wd_cnt - 16'd1;
          end
`endif
        end
        S_WRITE: begin
          for (int i = 0; i < N_NEURONS; i++) begin
            if (wb_valid && index == 2'(i)) pot[i] <= result_q;
          end
          if (is_last) begin
            state <= S_DONE;
          end else begin
            index         <= next_idx;
            dec_potential <= issue_pot;
            dec_rate      <= issue_rate;
            state         <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef DECAY_TIMEOUT_EN
  assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_decay_scheduler.sv
// Bench for decay_scheduler: directed checks of reset, sweep timing, rate
// codes, overrun, dropped writes and mid-sweep reset, then randomized rounds
// against a neuron-array reference model. The bench plays the decay unit,
// whose arithmetic is done on real numbers.

module tb_decay_scheduler;
  localparam int          N    = 4;
  localparam logic [31:0] INIT = 32'h41DED852;
  localparam int          TMO  = 16;

  logic        CLK = 1'b0;
  logic        RST, timestep, cfg_we, wr_en, dec_done;
  logic [1:0]  cfg_addr, wr_addr, rd_addr;
  logic [3:0]  cfg_rate;
  logic [31:0] wr_data, dec_result;
  logic        wr_ready, dec_req, busy, sweep_done, overrun, cfg_err, dec_err;
  logic [31:0] rd_data, dec_potential;
  logic [3:0]  dec_rate;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] pot_m  [N];
  logic [3:0]  rate_m [N];
  logic        overrun_m, dec_err_m;

  decay_scheduler #(.N_NEURONS(N), .INIT_POTENTIAL(INIT), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .timestep(timestep),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rate(cfg_rate),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .dec_req(dec_req), .dec_potential(dec_potential), .dec_rate(dec_rate),
    .dec_done(dec_done), .dec_result(dec_result),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun),
    .cfg_err(cfg_err), .dec_err(dec_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] b;
    b = $realtobits(x);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic bit legal_rate(input logic [3:0] r);
    return (r == 4'b0001 || r == 4'b0010 || r == 4'b0100 || r == 4'b1000 || r == 4'b0011);
  endfunction

  function automatic logic [31:0] decay_f(input logic [31:0] p, input logic [3:0] r);
    real k;
    case (r)
      4'b0010: k = 0.5;
      4'b0100: k = 0.25;
      4'b1000: k = 0.125;
      4'b0011: k = 0.75;
      default: k = 1.0;
    endcase
    return r2f(f2r(p) * k);
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pot_m[i]  = INIT;
      rate_m[i] = 4'b0001;
    end
    overrun_m = 1'b0;
    dec_err_m = 1'b0;
  endtask

  task automatic reset_dut();
    RST = 1'b1; timestep = 0; cfg_we = 0; wr_en = 0; dec_done = 0;
    cfg_addr = 0; cfg_rate = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; dec_result = 0;
    repeat (2) tick();
    RST = 1'b0;
    model_reset();
  endtask

  task automatic check_pots(input string tag);
    for (int i = 0; i < N; i++) begin
      rd_addr = 2'(i);
      #1;
      check_val(tag, rd_data, pot_m[i]);
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_wr_ready"}, wr_ready, 1);
    check_val({tag, "_overrun"}, overrun, overrun_m);
    check_val({tag, "_dec_err"}, dec_err, dec_err_m);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [3:0] r);
    cfg_we = 1; cfg_addr = a; cfg_rate = r;
    tick();
    cfg_we = 0;
    check_val("cfg_err_pulse", cfg_err, !legal_rate(r));
    if (legal_rate(r)) rate_m[a] = r;
    tick();
    check_val("cfg_err_clear", cfg_err, 0);
  endtask

  task automatic pot_write(input logic [1:0] a, input logic [31:0] d);
    check_val("wr_ready_idle", wr_ready, 1);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
    pot_m[a] = d;
  endtask

  // Lock-step sweep: the bench acts as the decay unit with a random wait of
  // 0..max_dly cycles per neuron and checks every request against the model.
  task automatic do_sweep(input int max_dly, input bit wr_same, input logic [31:0] wr_val,
                          input bit disturb, input int withhold);
    int d;
    logic [31:0] res;
    logic [3:0]  new_rate;
    timestep = 1;
    if (wr_same) begin
      wr_en = 1; wr_addr = 0; wr_data = wr_val;
      pot_m[0] = wr_val;
    end
    tick();
    timestep = 0; wr_en = 0;
    for (int k = 0; k < N; k++) begin
      check_val("issue_req", dec_req, 1);
      check_val("issue_pot", dec_potential, pot_m[k]);
      check_val("issue_rate", dec_rate, rate_m[k]);
      check_val("issue_busy", busy, 1);
      res = decay_f(pot_m[k], rate_m[k]);
      d = int'($urandom_range(0, max_dly));
      if (disturb && k == 1 && d == 0) d = 1;
      if (withhold == k) d = TMO - 1;
      tick();
      for (int w = 0; w < d; w++) begin
        check_val("wait_req_low", dec_req, 0);
        if (disturb && k == 1 && w == 0) begin
          new_rate = (rate_m[1] == 4'b1000) ? 4'b0100 : 4'b1000;
          timestep = 1;
          wr_en = 1; wr_addr = 2; wr_data = ~pot_m[2];
          cfg_we = 1; cfg_addr = 1; cfg_rate = new_rate;
          check_val("wr_ready_busy", wr_ready, 0);
        end
        tick();
        if (disturb && k == 1 && w == 0) begin
          timestep = 0; wr_en = 0; cfg_we = 0;
          check_val("rate_held", dec_rate, rate_m[1]);
          check_val("overrun_set", overrun, 1);
          rate_m[1]  = new_rate;
          overrun_m  = 1'b1;
        end
      end
      if (withhold == k) begin
        dec_err_m = 1'b1;
      end else begin
        dec_done = 1; dec_result = res;
      end
      tick();
      dec_done = 0; dec_result = $urandom;
      if (withhold != k) pot_m[k] = res;
      check_val("write_req_low", dec_req, 0);
      check_val("write_no_done", sweep_done, 0);
      tick();
    end
    check_val("sweep_done", sweep_done, 1);
    tick();
    check_val("sweep_done_once", sweep_done, 0);
    repeat (3) begin
      tick();
      check_val("no_extra_sweep", sweep_done, 0);
    end
  endtask

  logic [31:0] exp_rates [N];

  initial begin
    exp_rates = '{32'h41DED852, 32'h415ED852, 32'h40DED852, 32'h405ED852};

    // Reset values
    reset_dut();
    check_pots("reset_pot");
    check_status("reset");
    check_val("reset_req", dec_req, 0);
    check_val("reset_dec_pot", dec_potential, 0);
    check_val("reset_dec_rate", dec_rate, 0);
    check_val("reset_sweep_done", sweep_done, 0);
    check_val("reset_cfg_err", cfg_err, 0);

    // dec_done while idle does nothing
    dec_done = 1; dec_result = 32'h3F800000;
    tick();
    dec_done = 0;
    check_val("idle_done_busy", busy, 0);
    check_pots("idle_done_pot");

    // Four power-of-two rates, zero-wait unit, 13-cycle sweep
    cfg_write(0, 4'b0001);
    cfg_write(1, 4'b0010);
    cfg_write(2, 4'b0100);
    cfg_write(3, 4'b1000);
    do_sweep(0, 0, 0, 0, -1);
    for (int i = 0; i < N; i++) begin
      rd_addr = 2'(i);
      #1;
      check_val("rates_pot", rd_data, exp_rates[i]);
    end

    // Rate 0011 on 4.0, written in the same cycle as the timestep
    cfg_write(0, 4'b0011);
    do_sweep(0, 1, 32'h40800000, 0, -1);
    rd_addr = 0;
    #1;
    check_val("rate_0011", rd_data, 32'h40400000);

    // Illegal code leaves the rate alone (issue_rate checks it next sweep)
    cfg_write(1, 4'b0101);
    do_sweep(2, 0, 0, 0, -1);
    check_pots("illegal_cfg_pot");

    // Overrun, dropped write, rate change while neuron 1 is waiting
    do_sweep(2, 0, 0, 1, -1);
    check_pots("disturb_pot");
    check_status("disturb");
    do_sweep(1, 0, 0, 0, -1);
    check_pots("after_disturb_pot");

    // Reset while neuron 1 waits
    timestep = 1;
    tick();
    timestep = 0;
    tick();
    dec_done = 1; dec_result = 32'h3F800000;
    tick();
    dec_done = 0;
    tick();
    tick();
    RST = 1;
    tick();
    RST = 0;
    model_reset();
    check_pots("mid_reset_pot");
    check_status("mid_reset");
    repeat (6) begin
      check_val("mid_reset_no_done", sweep_done, 0);
      tick();
    end

`ifdef DECAY_TIMEOUT_EN
    do_sweep(0, 0, 0, 0, 2);
    check_pots("timeout_pot");
    check_status("timeout");
`endif

    // Randomized rounds
    for (int rnd = 0; rnd < 30; rnd++) begin
      for (int i = 0; i < N; i++) begin
        pot_write(2'(i), {1'($urandom), 8'($urandom_range(100, 150)), 21'($urandom), 2'b00});
      end
      repeat (2) cfg_write(2'($urandom), 4'($urandom));
      do_sweep(3, ($urandom_range(0, 3) == 0), {1'b0, 8'd127, 21'($urandom), 2'b00}, 0, -1);
      check_pots("rand_pot");
      check_status("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decay_scheduler.md
DECAY_SCHEDULER -- requirements
Module: decay_scheduler

Interface
REQ-001 Parameters SHALL be: N_NEURONS, default 4, number of neurons served; INIT_POTENTIAL, default 32'h41DED852, potential loaded at reset; TIMEOUT, default 16, watchdog limit in cycles.
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 timestep  in  1  one-cycle pulse starting a decay sweep.
REQ-005 cfg_we / cfg_addr / cfg_rate  in  1/2/4  decay-rate configuration write.
REQ-006 wr_en / wr_addr / wr_data  in  1/2/32  potential update from the adder side; wr_ready  out  1  write accepted.
REQ-007 rd_addr  in  2; rd_data  out  32  combinational read of the stored potential.
REQ-008 dec_req  out  1; dec_potential  out  32; dec_rate  out  4  request to the shared decay unit.
REQ-009 dec_done  in  1; dec_result  in  32  decay unit completion and result.
REQ-010 busy  out  1; sweep_done  out  1 (one-cycle pulse); overrun  out  1 (sticky); cfg_err  out  1 (one-cycle pulse); dec_err  out  1 (sticky).

Function
REQ-011 Storage SHALL be N_NEURONS 32-bit IEEE-754 potential registers and N_NEURONS 4-bit rate registers.
REQ-012 Legal rate codes SHALL be 0001 (/1), 0010 (/2), 0100 (/4), 1000 (/8), 0011 (/2 + /4); a cfg_we with any other code leaves the register unchanged and pulses cfg_err.
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-014 IDLE: timestep=1 -> ISSUE with index=0; busy=0 only in IDLE.
REQ-015 ISSUE: dec_req=1 for exactly one cycle with dec_potential=pot[index], dec_rate=rate[index]; next state WAIT.
REQ-016 WAIT: hold dec_potential/dec_rate stable; on dec_done=1 capture dec_result and go to WRITE; dec_done outside WAIT is ignored.
REQ-017 WRITE: pot[index] <= captured result; if index==N_NEURONS-1 go to DONE, else index+1 and go to ISSUE.
REQ-018 DONE: sweep_done=1 for one cycle, then IDLE.
REQ-019 Sweep latency with a zero-wait decay unit (dec_done in the first WAIT cycle) SHALL be 3*N_NEURONS+1 cycles from timestep to sweep_done.
REQ-020 wr_ready SHALL equal 1 in IDLE only; a write with wr_en=1 and wr_ready=1 updates pot[wr_addr] on that edge; writes with wr_ready=0 are dropped, and the requester holds them.
REQ-021 timestep and wr_en in the same IDLE cycle: the write SHALL land first, and the sweep decays the written value.
REQ-022 timestep while busy=1 SHALL be ignored and SHALL set overrun.
REQ-023 cfg_we SHALL be accepted in any state; a rate change to the neuron currently in WAIT takes effect at the next sweep because dec_rate is held.
REQ-024 overrun and dec_err SHALL clear only on RST.

Reset
REQ-025 On RST: state=IDLE, index=0, every pot=INIT_POTENTIAL, every rate=0001, dec_req=0, dec_potential=0, dec_rate=0, busy=0, sweep_done=0, overrun=0, cfg_err=0, dec_err=0.
REQ-026 RST asserted mid-sweep SHALL abort on that edge with no further write-back and no sweep_done.

Configuration
REQ-027 Macro DECAY_TIMEOUT_EN SHALL gate a WAIT watchdog.
REQ-028 With DECAY_TIMEOUT_EN defined: if TIMEOUT cycles elapse in WAIT without dec_done, set dec_err, leave pot[index] unchanged, and continue as from WRITE.
REQ-029 Without DECAY_TIMEOUT_EN: WAIT SHALL wait indefinitely and dec_err SHALL be tied to 0.

Verification
REQ-030 Reset, then read all addresses -> rd_data=32'h41DED852 for each; busy=0.
REQ-031 Rates {0001,0010,0100,1000}, zero-wait model, one timestep -> pots become 41DED852, 415ED852, 40DED852, 405ED852; sweep_done exactly 13 cycles after timestep.
REQ-032 Rate 0011 on neuron 0 with pot=40800000 (4.0) -> pot becomes 40400000 (3.0).
REQ-033 timestep during a sweep -> overrun=1 and only one sweep_done; wr_en during the sweep -> wr_ready=0 and pot unchanged.
REQ-034 cfg_rate=0101 -> cfg_err pulses and the rate is unchanged; RST in WAIT -> all pots return to 41DED852 and there is no sweep_done.
REQ-035 With DECAY_TIMEOUT_EN and dec_done withheld for neuron 2 -> dec_err=1 after 16 WAIT cycles, pot[2] unchanged, and the sweep completes.
